rr_req_gnt_arb: RTL and testbench

Round-robin arbiter that shares one REQ/GNT-handshaked resource among `NREQ` requesters. It issues a registered one-hot grant and bounds each tenure to `MAX_TENURE` cycles. It also keeps running request and grant totals, which assertion checkers compare against each other. It sits between the requester agents and the shared resource, in front of the REQ→GNT checkers.

---
 rtl/arb_pkg.sv | 16 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_req_gnt_arb.sv | 105 ++++++++++
 tb/tb_rr_req_gnt_arb.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state type, default parameters and popcount helper for the round-robin arbiter.
package arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    localparam int DEF_NREQ         = 4;
    localparam int DEF_MAX_TENURE   = 8;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_STARVE_LIMIT = 64;

    function automatic int popcount(input logic [15:0] v);
        popcount = 0;
        for (int i = 0; i < 16; i++) popcount += int'(v[i]);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting just after i_last_id.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last_id,
    output logic [IW-1:0]   o_win,
    output logic            o_vld
);

    logic [IW-1:0] w_idx;

    // Walk the ring backwards so the nearest requester after i_last_id is written last.
    always_comb begin
        o_win = '0;
        o_vld = 1'b0;
        w_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = IW'((int'(i_last_id) + k) % NREQ);
            if (i_req[w_idx]) begin
                o_win = w_idx;
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_req_gnt_arb.sv
// rr_req_gnt_arb: round-robin REQ/GNT arbiter with bounded tenure and request/grant totals.
// Define ARB_STARVE_CHK_EN to build per-requester wait counters driving the sticky starve_err.
module rr_req_gnt_arb
    import arb_pkg::*;
#(
    parameter int NREQ         = DEF_NREQ,
    parameter int MAX_TENURE   = DEF_MAX_TENURE,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          gnt,
    output logic [$clog2(NREQ)-1:0]  gnt_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         req_cnt,
    output logic [CNT_W-1:0]         gnt_cnt,
    output logic                     starve_err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(MAX_TENURE + 1);

    arb_state_t      r_state, w_state_nx;
    logic [NREQ-1:0] r_gnt, r_req_q;
    logic [IW-1:0]   r_gnt_id, r_last_id, w_win;
    logic [TW-1:0]   r_tcnt;
    logic [CNT_W-1:0] r_req_cnt, r_gnt_cnt;
    logic            w_vld, w_grant, w_release;

    // Arbitration looks at last cycle's requests, giving the one-cycle request-to-grant pipeline.
    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .i_req     (r_req_q),
        .i_last_id (r_last_id),
        .o_win     (w_win),
        .o_vld     (w_vld)
    );

    always_comb begin
        w_grant    = 1'b0;
        w_release  = 1'b0;
        w_state_nx = r_state;
        if (r_state == IDLE) begin
            w_grant    = w_vld;
            w_state_nx = w_vld ? GRANT : IDLE;
        end else begin
            w_release  = !req[r_gnt_id] || r_tcnt == TW'(MAX_TENURE - 1);
            w_state_nx = w_release ? IDLE : GRANT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_last_id <= IW'(NREQ - 1);
            r_tcnt    <= '0;
            r_req_q   <= '0;
            r_req_cnt <= '0;
            r_gnt_cnt <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_req_q   <= req;
            r_req_cnt <= r_req_cnt + CNT_W'(popcount(16'(req & ~r_req_q)));
            if (w_grant) begin
                r_gnt     <= NREQ'(1) << w_win;
                r_gnt_id  <= w_win;
                r_last_id <= w_win;
                r_tcnt    <= '0;
                r_gnt_cnt <= r_gnt_cnt + CNT_W'(1);
            end else if (w_release) begin
                r_gnt <= '0;
            end else if (r_state == GRANT) begin
                r_tcnt <= r_tcnt + TW'(1);
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_id  = r_gnt_id;
    assign busy    = |r_gnt;
    assign req_cnt = r_req_cnt;
    assign gnt_cnt = r_gnt_cnt;

`ifdef ARB_STARVE_CHK_EN
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [NREQ-1:0] w_full;
    logic            r_starve;
    for (genvar i = 0; i < NREQ; i++) begin : g_wait
        logic [SW-1:0] r_wait;
        assign w_full[i] = r_wait == SW'(STARVE_LIMIT);
        always_ff @(posedge clk) begin
            if (reset || !req[i] || r_gnt[i]) r_wait <= '0;
            else if (!w_full[i]) r_wait <= r_wait + SW'(1);
        end
    end
    always_ff @(posedge clk) r_starve <= !reset && (r_starve || |w_full);
    assign starve_err = r_starve;
`else
    assign starve_err = STARVE_LIMIT < 0;
`endif

endmodule

// File: tb/tb_rr_req_gnt_arb.sv
// tb_rr_req_gnt_arb: directed and random stimulus checked against a cycle-level behavioural model.
module tb_rr_req_gnt_arb;

    localparam int N  = 4;
    localparam int MT = 8;
    localparam int CW = 16;
    localparam int SL = 4;
`ifdef ARB_STARVE_CHK_EN
    localparam logic STARVE_EXP = 1'b1;
`else
    localparam logic STARVE_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  gnt;
    logic [1:0]    gnt_id;
    logic          busy, starve_err;
    logic [CW-1:0] req_cnt, gnt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_req_gnt_arb #(.NREQ(N), .MAX_TENURE(MT), .CNT_W(CW), .STARVE_LIMIT(SL)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .req_cnt    (req_cnt),
        .gnt_cnt    (gnt_cnt),
        .starve_err (starve_err)
    );

    // Model state: who holds the resource, for how long, and last cycle's request vector.
    int            m_holder, m_len, m_last, m_id;
    logic [CW-1:0] m_reqc, m_gntc;
    logic [N-1:0]  m_prev;
    logic          m_starve;
    int            m_wait [N];
    int            starts [$];
    logic          g_was;
    int            n_hi0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_holder = -1;
        m_len    = 0;
        m_last   = N - 1;
        m_id     = 0;
        m_reqc   = '0;
        m_gntc   = '0;
        m_prev   = '0;
        m_starve = 1'b0;
        for (int i = 0; i < N; i++) m_wait[i] = 0;
    endtask

    task automatic model(input logic [N-1:0] r);
        int w;
`ifdef ARB_STARVE_CHK_EN
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            hit |= (m_wait[i] == SL);
            m_wait[i] = (!r[i] || m_holder == i) ? 0 : (m_wait[i] < SL ? m_wait[i] + 1 : SL);
        end
        m_starve |= hit;
`endif
        m_reqc += CW'($countones(r & ~m_prev));
        if (m_holder >= 0) begin
            if (!r[m_holder] || m_len == MT) m_holder = -1;
            else m_len++;
        end else if (m_prev != '0) begin
            w = -1;
            for (int k = 1; k <= N && w < 0; k++)
                if (m_prev[(m_last + k) % N]) w = (m_last + k) % N;
            m_holder = w;
            m_len    = 1;
            m_last   = w;
            m_id     = w;
            m_gntc++;
        end
        m_prev = r;
    endtask

    task automatic step(input logic [N-1:0] r, input logic rst);
        @(negedge clk);
        req   = r;
        reset = rst;
        @(posedge clk);
        if (rst) model_reset();
        else model(r);
        #1;
        if (|gnt && !g_was) starts.push_back(int'(gnt_id));
        g_was = |gnt;
        if (gnt[0]) n_hi0++;
        chk("gnt", 32'(gnt), m_holder >= 0 ? 32'(1) << m_holder : 32'(0));
        chk("gnt_id", 32'(gnt_id), 32'(m_id));
        chk("busy", 32'(busy), 32'(m_holder >= 0));
        chk("req_cnt", 32'(req_cnt), 32'(m_reqc));
        chk("gnt_cnt", 32'(gnt_cnt), 32'(m_gntc));
        chk("starve_err", 32'(starve_err), 32'(m_starve));
    endtask

    initial begin
        logic [N-1:0] rv;
        int           exp_ord [5] = '{0, 1, 2, 3, 0};
        model_reset();
        g_was = 1'b0;
        n_hi0 = 0;

        repeat (3) step('0, 1'b1);
        chk("rst_all", {28'(gnt), 2'(gnt_id), 1'(busy), 1'(starve_err)}, 0);
        repeat (3) step('0, 1'b0);
        chk("rst_cnts", 32'({req_cnt, gnt_cnt}), 0);

        n_hi0 = 0;
        repeat (4) step(4'b0001, 1'b0);
        repeat (3) step('0, 1'b0);
        chk("single_width", 32'(n_hi0), 3);
        chk("single_req_cnt", 32'(req_cnt), 1);
        chk("single_gnt_cnt", 32'(gnt_cnt), 1);
        chk("single_gnt_id", 32'(gnt_id), 0);

        step('0, 1'b1);
        starts.delete();
        repeat (45) step(4'hF, 1'b0);
        chk("fair_gnt_cnt", 32'(gnt_cnt), 5);
        chk("fair_req_cnt", 32'(req_cnt), 4);
        chk("fair_n", 32'(starts.size()), 5);
        for (int i = 0; i < 5; i++)
            chk("fair_order", i < starts.size() ? 32'(starts[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));

        step('0, 1'b1);
        step('0, 1'b0);
        step(4'b1010, 1'b0);
        chk("simul_req_cnt", 32'(req_cnt), 2);
        starts.delete();
        repeat (25) step(4'b1010, 1'b0);
        chk("simul_first", starts.size() > 0 ? 32'(starts[0]) : 32'hFFFF_FFFF, 1);
        chk("simul_second", starts.size() > 1 ? 32'(starts[1]) : 32'hFFFF_FFFF, 3);

        step('0, 1'b1);
        repeat (4) step(4'b0100, 1'b0);
        chk("mid_holder", 32'(gnt), 32'h4);
        step(4'b0100, 1'b1);
        chk("midrst_gnt", 32'(gnt), 0);
        starts.delete();
        repeat (3) step(4'hF, 1'b0);
        chk("midrst_next", starts.size() > 0 ? 32'(starts[0]) : 32'hFFFF_FFFF, 0);

        step('0, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0001, 1'b0);
        repeat (13) step(4'b0011, 1'b0);
        chk("starve_gnt1", 32'(gnt), 32'h2);
        chk("starve_flag", 32'(starve_err), 32'(STARVE_EXP));

        step('0, 1'b1);
        rv = '0;
        repeat (400) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 5) == 0) rv[i] = ~rv[i];
            step(rv, $urandom_range(0, 63) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
